// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser, debounce filter and press/release strobe generator.
// Optional long-press strobe enabled by defining KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_MAX  = 1000000,
  parameter int LONG_MAX = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  ,
  output logic [NUM_KEYS-1:0] key_long
`endif
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];

  // two-flop synchroniser, idle-high so reset looks like "released"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= {NUM_KEYS{1'b1}};
      s2_q <= {NUM_KEYS{1'b1}};
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  // debounce next-state: any agreeing cycle clears the run count
  always_comb begin
    level_d   = level_q;
    press_d   = {NUM_KEYS{1'b0}};
    release_d = {NUM_KEYS{1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (s2_q[k] == level_q[k]) begin
        cnt_d[k] = {CW{1'b0}};
      end else if (cnt_q[k] == CNT_LAST) begin
        cnt_d[k]     = {CW{1'b0}};
        level_d[k]   = s2_q[k];
        press_d[k]   = ~s2_q[k];
        release_d[k] = s2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end
  end

  // debounce state and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= {NUM_KEYS{1'b1}};
      press_q   <= {NUM_KEYS{1'b0}};
      release_q <= {NUM_KEYS{1'b0}};
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= {CW{1'b0}};
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
  localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_MAX);

  logic [NUM_KEYS-1:0] long_q, long_d;
  logic [LW-1:0]       hold_q [NUM_KEYS];
  logic [LW-1:0]       hold_d [NUM_KEYS];

  // hold counter saturates at the top so the strobe fires once per press
  always_comb begin
    long_d = {NUM_KEYS{1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      hold_d[k] = hold_q[k];
      if (level_q[k]) begin
        hold_d[k] = {LW{1'b0}};
      end else if (hold_q[k] == LONG_TOP) begin
        hold_d[k] = hold_q[k];
      end else begin
        hold_d[k] = hold_q[k] + LW'(1);
        long_d[k] = (hold_q[k] == LONG_LAST);
      end
    end
  end

  // long-press state and registered strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_q <= {NUM_KEYS{1'b0}};
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= {LW{1'b0}};
      end
    end else begin
      long_q <= long_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign key_long = long_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=4, LONG_MAX=10, NUM_KEYS=4.
module tb_key_debounce;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  logic [NK-1:0] key_long;
`endif

  int n_cmp = 0;
  int n_err = 0;

  key_debounce #(.NUM_KEYS(NK), .CNT_MAX(4), .LONG_MAX(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    ,
    .key_long    (key_long)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    key_raw = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("rst_level", key_level, 4'b1111);
    chk("rst_press", key_press, 4'b0000);
    chk("rst_release", key_release, 4'b0000);
    tick();
    #3 rst = 1'b0;

    // get all keys accepted low, then reset mid-cycle with no clock edge
    tick();
    key_raw = 4'b0000;
    ticks(6);
    chk("pre_level", key_level, 4'b0000);
    chk("pre_press", key_press, 4'b1111);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("async_level", key_level, 4'b1111);
    chk("async_press", key_press, 4'b0000);
    tick();
    #3 rst = 1'b0;
    ticks(5);
    chk("rel5_level", key_level, 4'b1111);
    tick();
    chk("rel6_level", key_level, 4'b0000);
    chk("rel6_press", key_press, 4'b1111);
    key_raw = 4'b1111;
    ticks(6);
    chk("rel_all_release", key_release, 4'b1111);
    chk("rel_all_level", key_level, 4'b1111);
    tick();
    chk("rel_all_release_off", key_release, 4'b0000);

    // clean press on key 0, held well past acceptance
    key_raw = 4'b1110;
    ticks(5);
    chk("clean5_level", key_level, 4'b1111);
    chk("clean5_press", key_press, 4'b0000);
    tick();
    chk("clean6_level", key_level, 4'b1110);
    chk("clean6_press", key_press, 4'b0001);
    chk("clean6_release", key_release, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("held_press", key_press, 4'b0000);
      chk("held_level", key_level, 4'b1110);
    end
    key_raw = 4'b1111;
    ticks(5);
    chk("k0rel5_release", key_release, 4'b0000);
    tick();
    chk("k0rel6_release", key_release, 4'b0001);
    chk("k0rel6_press", key_press, 4'b0000);
    tick();
    chk("k0rel7_release", key_release, 4'b0000);

    // bounce on key 1: 3-low, 1-high, 3-low, 1-high, then held low
    for (int seg = 0; seg < 2; seg++) begin
      key_raw = 4'b1101;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("bounce_press", key_press, 4'b0000);
        chk("bounce_level", key_level, 4'b1111);
      end
      key_raw = 4'b1111;
      tick();
      chk("bounce_press", key_press, 4'b0000);
      chk("bounce_level", key_level, 4'b1111);
    end
    key_raw = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("settle_press", key_press, 4'b0000);
      chk("settle_level", key_level, 4'b1111);
    end
    tick();
    chk("settle6_press", key_press, 4'b0010);
    chk("settle6_level", key_level, 4'b1101);
    tick();
    chk("settle7_press", key_press, 4'b0000);
    key_raw = 4'b1111;
    ticks(6);
    chk("k1_release", key_release, 4'b0010);
    tick();

    // simultaneous press and release of keys 1 and 3
    key_raw = 4'b0101;
    ticks(5);
    chk("sim5_press", key_press, 4'b0000);
    tick();
    chk("sim_press", key_press, 4'b1010);
    chk("sim_level", key_level, 4'b0101);
    tick();
    chk("sim_press_off", key_press, 4'b0000);
    key_raw = 4'b1111;
    ticks(6);
    chk("sim_release", key_release, 4'b1010);
    chk("sim_rel_level", key_level, 4'b1111);
    tick();
    chk("sim_release_off", key_release, 4'b0000);

    // reset part-way through debouncing key 2
    key_raw = 4'b1011;
    ticks(3);
    #3 rst = 1'b1;
    #1;
    chk("midrst_level", key_level, 4'b1111);
    tick();
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_wait_level", key_level, 4'b1111);
      chk("midrst_wait_press", key_press, 4'b0000);
    end
    tick();
    chk("midrst_level6", key_level, 4'b1011);
    chk("midrst_press6", key_press, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_once", key_press, 4'b0000);
    end
    key_raw = 4'b1111;
    ticks(6);
    chk("midrst_release", key_release, 4'b0100);
    tick();

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    // long press on key 3, twice
    for (int rep = 0; rep < 2; rep++) begin
      key_raw = 4'b0111;
      ticks(6);
      chk("long_fall", key_level, 4'b0111);
      for (int i = 0; i < 9; i++) begin
        tick();
        chk("long_early", key_long, 4'b0000);
      end
      tick();
      chk("long_pulse", key_long, 4'b1000);
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("long_after", key_long, 4'b0000);
      end
      key_raw = 4'b1111;
      ticks(6);
      chk("long_release", key_release, 4'b1000);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
